// File: rtl/keypad_timer_input_pkg.sv
// Shared types and sizing helpers for the microwave keypad/timer front end.
package keypad_timer_input_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StHeld,
        StRelease
    } kt_state_e;

    localparam logic ModeEntry = 1'b0;
    localparam logic ModeCount = 1'b1;

    // Counter width able to hold 0..v; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v == 0) ? 1 : $clog2(v + 1);
    endfunction

    function automatic int unsigned code_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_timer_input_tick_divider.sv
// Free-running clock divider: one-cycle tick every DIV clocks, shared with the cooking timer.
module tick_divider
    import keypad_timer_input_pkg::*;
#(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic clearn,
    output logic tick
);

    localparam int unsigned CW = cnt_width(DIV);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_timer_input.sv
// Keypad front end: sync, priority encode, debounce FSM and digit strobe; in count
// mode pgt_1Hz carries the divided tick instead of key strobes.
module keypad_timer_input
    import keypad_timer_input_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 10,
    parameter int unsigned CLK_DIV      = 100,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned REPEAT_CYC   = 0,
    localparam int unsigned CODE_W      = code_width(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                clearn,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    output logic                loadn,
    output logic [CODE_W-1:0]   D,
    output logic                pgt_1Hz
);

    localparam int unsigned DB_W     = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned REP_W    = cnt_width(REPEAT_CYC);
    localparam int unsigned REP_LAST = (REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [CODE_W-1:0]   enc_code;
    logic                any_key;
    logic                tick;
    logic                strobe;

    kt_state_e           state_q;
    logic [CODE_W-1:0]   code_q;
    logic [DB_W-1:0]     stable_cnt_q;
    logic [REP_W-1:0]    rep_cnt_q;

    tick_divider #(
        .DIV (CLK_DIV)
    ) u_tick_divider (
        .clk    (clk),
        .clearn (clearn),
        .tick   (tick)
    );

    // Highest asserted index wins.
    always_comb begin
        enc_code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync2_q[i]) begin
                enc_code = CODE_W'(i);
            end
        end
    end

    assign any_key = |sync2_q;

    always_comb begin
        strobe = 1'b0;
        if (enablen == ModeEntry) begin
            case (state_q)
                StDebounce: strobe = any_key && (enc_code == code_q) &&
                                     (stable_cnt_q == DB_W'(DEBOUNCE_CYC));
                StHeld:     strobe = (REPEAT_CYC > 0) && any_key &&
                                     (rep_cnt_q == REP_W'(REP_LAST));
                default:    strobe = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= StIdle;
            code_q       <= '0;
            stable_cnt_q <= '0;
            rep_cnt_q    <= '0;
            loadn        <= 1'b1;
            D            <= '0;
            pgt_1Hz      <= 1'b0;
        end else begin
            sync1_q <= keypad;
            sync2_q <= sync1_q;
            loadn   <= ~strobe;
            // In entry mode the tick is dropped so only key strobes reach pgt_1Hz.
            pgt_1Hz <= (enablen == ModeCount) ? tick : strobe;
            if (strobe) begin
                D <= code_q;
            end

            if (enablen == ModeCount) begin
                state_q      <= StIdle;
                stable_cnt_q <= '0;
                rep_cnt_q    <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (any_key) begin
                            state_q      <= StDebounce;
                            code_q       <= enc_code;
                            stable_cnt_q <= DB_W'(1);
                        end
                    end
                    StDebounce: begin
                        if (!any_key) begin
                            state_q      <= StIdle;
                            stable_cnt_q <= '0;
                        end else if (enc_code != code_q) begin
                            code_q       <= enc_code;
                            stable_cnt_q <= DB_W'(1);
                        end else if (strobe) begin
                            state_q   <= StHeld;
                            rep_cnt_q <= '0;
                        end else begin
                            stable_cnt_q <= stable_cnt_q + 1'b1;
                        end
                    end
                    StHeld: begin
                        // Code changes while held are ignored: no rollover.
                        if (!any_key) begin
                            state_q      <= StRelease;
                            stable_cnt_q <= DB_W'(1);
                        end else if (REPEAT_CYC > 0) begin
                            if (rep_cnt_q == REP_W'(REP_LAST)) begin
                                rep_cnt_q <= '0;
                            end else begin
                                rep_cnt_q <= rep_cnt_q + 1'b1;
                            end
                        end
                    end
                    StRelease: begin
                        if (any_key) begin
                            state_q <= StHeld;
                        end else if (stable_cnt_q == DB_W'(DEBOUNCE_CYC)) begin
                            state_q      <= StIdle;
                            stable_cnt_q <= '0;
                        end else begin
                            stable_cnt_q <= stable_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_timer_input.sv
// Scoreboard bench: stimulus queues expected strobes, negedge monitors pop and compare.
module tb_keypad_timer_input;

    localparam int NK = 10;
    localparam int CW = 4;
    // Edges from keypad change to loadn low: 2 sync + 1 entry + DEBOUNCE_CYC(4).
    localparam int LAT = 7;

    typedef struct {
        logic [CW-1:0] d;
        int            at;
    } exp_t;

    logic          clk = 1'b0;
    logic          clearn = 1'b0;
    logic          enablen = 1'b0;
    logic [NK-1:0] kp0 = '0;
    logic [NK-1:0] kp1 = '0;
    logic          loadn0, loadn1, pgt0, pgt1;
    logic [CW-1:0] d0, d1;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   entry_chk = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    keypad_timer_input #(
        .NUM_KEYS     (NK),
        .CLK_DIV      (100),
        .DEBOUNCE_CYC (4),
        .REPEAT_CYC   (0)
    ) dut (
        .clk     (clk),
        .clearn  (clearn),
        .keypad  (kp0),
        .enablen (enablen),
        .loadn   (loadn0),
        .D       (d0),
        .pgt_1Hz (pgt0)
    );

    keypad_timer_input #(
        .NUM_KEYS     (NK),
        .CLK_DIV      (100),
        .DEBOUNCE_CYC (4),
        .REPEAT_CYC   (50)
    ) dut_rep (
        .clk     (clk),
        .clearn  (clearn),
        .keypad  (kp1),
        .enablen (enablen),
        .loadn   (loadn1),
        .D       (d1),
        .pgt_1Hz (pgt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected none (cycle %0d)", name, act, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (clearn) begin
            if (loadn0 === 1'b0) begin
                if (q0.size() == 0) begin
                    fail("strobe0_unexpected", d0);
                end else begin
                    chk("strobe0_d", d0, q0[0].d);
                    chk("strobe0_cycle", cyc, q0[0].at);
                    chk("strobe0_pgt", pgt0, 1);
                    void'(q0.pop_front());
                end
            end else if (entry_chk && pgt0 !== 1'b0) begin
                fail("pgt0_without_strobe", pgt0);
            end
        end
    end

    always @(negedge clk) begin
        if (clearn) begin
            if (loadn1 === 1'b0) begin
                if (q1.size() == 0) begin
                    fail("strobe1_unexpected", d1);
                end else begin
                    chk("strobe1_d", d1, q1[0].d);
                    chk("strobe1_cycle", cyc, q1[0].at);
                    chk("strobe1_pgt", pgt1, 1);
                    void'(q1.pop_front());
                end
            end else if (entry_chk && pgt1 !== 1'b0) begin
                fail("pgt1_without_strobe", pgt1);
            end
        end
    end

    initial begin
        int  last;
        int  pulses;
        bit  prev;

        // Reset state
        wait_cyc(3);
        chk("rst_loadn0", loadn0, 1);
        chk("rst_d0", d0, 0);
        chk("rst_pgt0", pgt0, 0);
        chk("rst_loadn1", loadn1, 1);
        chk("rst_d1", d1, 0);
        chk("rst_pgt1", pgt1, 0);
        clearn = 1'b1;
        wait_cyc(5);
        entry_chk = 1'b1;

        // Clean press of key 7, held 200 cycles, no repeat
        kp0 = NK'(1) << 7;
        q0.push_back(exp_t'{4'd7, cyc + LAT});
        wait_cyc(LAT + 200);
        kp0 = '0;
        wait_cyc(20);

        // Bounce on key 3: 2-cycle pulses never reach the debounce count
        for (int i = 0; i < 10; i++) begin
            kp0 = (i % 2 == 0) ? (NK'(1) << 3) : '0;
            wait_cyc(2);
        end
        kp0 = NK'(1) << 3;
        q0.push_back(exp_t'{4'd3, cyc + LAT});
        wait_cyc(LAT + 10);
        for (int i = 0; i < 10; i++) begin
            kp0 = (i % 2 == 0) ? '0 : (NK'(1) << 3);
            wait_cyc(2);
        end
        kp0 = '0;
        wait_cyc(20);

        // Priority: 2 and 9 together -> 9; dropping 9 leaves 2 held, no strobe
        kp0 = (NK'(1) << 2) | (NK'(1) << 9);
        q0.push_back(exp_t'{4'd9, cyc + LAT});
        wait_cyc(LAT + 20);
        kp0 = NK'(1) << 2;
        wait_cyc(30);
        kp0 = '0;
        wait_cyc(20);
        chk("d_holds_last", d0, 9);

        // Asynchronous reset mid-debounce with key held
        kp0 = NK'(1) << 3;
        wait_cyc(4);
        clearn = 1'b0;
        #1;
        chk("midrst_loadn0", loadn0, 1);
        chk("midrst_d0", d0, 0);
        chk("midrst_pgt0", pgt0, 0);
        chk("midrst_d1", d1, 0);
        @(negedge clk);
        clearn = 1'b1;
        q0.push_back(exp_t'{4'd3, cyc + LAT});
        wait_cyc(LAT + 20);
        kp0 = '0;
        wait_cyc(20);

        // Count mode: 100-cycle ticks of width 1, keypad ignored
        entry_chk = 1'b0;
        enablen = 1'b1;
        kp0 = NK'(1) << 4;
        kp1 = NK'(1) << 6;
        last = -1;
        pulses = 0;
        prev = 1'b0;
        for (int n = 0; n < 350; n++) begin
            @(negedge clk);
            if (pgt0 === 1'b1) begin
                chk("count_width", prev, 0);
                if (last >= 0) chk("count_period", cyc - last, 100);
                last = cyc;
                pulses++;
            end
            prev = pgt0;
        end
        chk("count_pulses_ge3", (pulses >= 3) ? 1 : 0, 1);
        kp0 = '0;
        kp1 = '0;
        wait_cyc(10);
        enablen = 1'b0;
        wait_cyc(3);
        entry_chk = 1'b1;

        // Auto-repeat every 50 cycles on key 5, held 160 cycles after accept
        kp1 = NK'(1) << 5;
        for (int k = 0; k < 4; k++) begin
            q1.push_back(exp_t'{4'd5, cyc + LAT + 50 * k});
        end
        wait_cyc(LAT + 160);
        kp1 = '0;
        wait_cyc(30);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
